// File: rtl/async_queue_pkg.sv
// Shared constants, D-channel payload layout and Gray helper for the async queue.
// Every field offset is an LSB position inside the packed beat.
package async_queue_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 44;
    localparam int SYNC_DEF  = 3;

    localparam int CORRUPT_LSB = 0;
    localparam int DENIED_LSB  = 1;
    localparam int DATA_LSB    = 2;
    localparam int SOURCE_LSB  = 34;
    localparam int SIZE_LSB    = 36;
    localparam int PARAM_LSB   = 39;
    localparam int OPCODE_LSB  = 41;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [1:0]  source;
        logic [31:0] data;
        logic        denied;
        logic        corrupt;
    } d_beat_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_sync_chain.sv
// Multi-flop synchronizer for a Gray-coded index; all stages clear to zero on reset.
module async_sync_chain
    import async_queue_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = SYNC_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/async_queue_source_d8.sv
// Source (write) side of a Gray-indexed asynchronous crossing queue.
// Entries live in plain flops so the sink domain can read them at any time.
module async_queue_source_d8
    import async_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int SYNC  = SYNC_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [WIDTH-1:0]         enq_bits,
    output logic [DEPTH*WIDTH-1:0]   mem,
    output logic [$clog2(DEPTH):0]   widx,
    input  logic [$clog2(DEPTH):0]   ridx
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    // Full when the write index is exactly one lap ahead: Gray MSB pair inverted.
    localparam logic [IW-1:0] FULL_MASK = IW'(3) << (IW - 2);

    logic [IW-1:0]                wbin;
    logic [IW-1:0]                wbin_next;
    logic [IW-1:0]                ridx_s;
    logic [DEPTH-1:0][WIDTH-1:0]  store;
    logic                         full;
    logic                         fire;

    async_sync_chain #(
        .WIDTH  (IW),
        .STAGES (SYNC)
    ) u_ridx_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (ridx),
        .q       (ridx_s)
    );

    assign full      = (widx == (ridx_s ^ FULL_MASK));
    assign enq_ready = !full;
    assign fire      = enq_valid && enq_ready;
    assign wbin_next = wbin + IW'(1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wbin <= '0;
            widx <= '0;
        end else if (fire) begin
            wbin <= wbin_next;
            widx <= IW'(bin2gray(32'(wbin_next)));
        end
    end

    // NOTE: storage has no reset; only the indices define which entries are valid.
    always_ff @(posedge clock) begin
        if (reset_n && fire) begin
            store[wbin[AW-1:0]] <= enq_bits;
        end
    end

    assign mem = store;

endmodule

// File: tb/tb_async_queue_source_d8.sv
// Directed bench for async_queue_source_d8 (DEPTH=8, SYNC=3) acting as the sink side.
module tb_async_queue_source_d8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enq_valid;
    logic         enq_ready;
    logic [43:0]  enq_bits;
    logic [351:0] mem;
    logic [3:0]   widx;
    logic [3:0]   ridx;

    int errors = 0;
    int checks = 0;
    int wabs, rabs, p1, p2, p3, slot;
    bit exp_rdy;
    int widx_tab [8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    always #5 clock = ~clock;

    async_queue_source_d8 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .mem       (mem),
        .widx      (widx),
        .ridx      (ridx)
    );

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [43:0] payload(input int n);
        return 44'(n + 1);
    endfunction

    function automatic logic [43:0] entry(input int i);
        return mem[(i % 8) * 44 +: 44];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enq_valid = 1'b0;
        enq_bits  = '0;
        ridx      = '0;
        step();
        step();
        check("reset_widx", 64'(widx), 64'd0);
        check("reset_sync", 64'(dut.ridx_s), 64'd0);
        reset_n = 1'b1;
        check("ready_after_reset", 64'(enq_ready), 64'd1);

        // Fill all eight entries with 0x1..0x8.
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_bits  = 44'(i + 1);
            check("fill_ready", 64'(enq_ready), 64'd1);
            step();
            check("fill_widx", 64'(widx), 64'(widx_tab[i]));
        end
        check("full_ready_low", 64'(enq_ready), 64'd0);
        for (int i = 0; i < 8; i++) check("fill_entry", 64'(entry(i)), 64'(i + 1));

        // Producer keeps pushing while full: nothing moves.
        enq_bits = 44'hAAA;
        for (int i = 0; i < 10; i++) begin
            step();
            check("full_hold_widx", 64'(widx), 64'd12);
            check("full_hold_ready", 64'(enq_ready), 64'd0);
        end
        for (int i = 0; i < 8; i++) check("full_hold_entry", 64'(entry(i)), 64'(i + 1));

        // One read index step propagates to ready after three edges.
        ridx     = 4'd1;
        enq_bits = 44'h9;
        step();
        check("sync_lat_1", 64'(enq_ready), 64'd0);
        step();
        check("sync_lat_2", 64'(enq_ready), 64'd0);
        step();
        check("sync_lat_3", 64'(enq_ready), 64'd1);
        check("sync_lat_widx", 64'(widx), 64'd12);
        step();
        check("refill_widx", 64'(widx), 64'd13);
        check("refill_entry0", 64'(entry(0)), 64'h9);
        check("refill_full", 64'(enq_ready), 64'd0);
        enq_valid = 1'b0;
        wabs = 9;

        // Sink jumps to 5 and lets it settle before streaming.
        rabs = 5;
        ridx = gray4(rabs);
        step();
        step();
        step();
        check("stream_pre_ready", 64'(enq_ready), 64'd1);

        // Streaming with the sink four beats behind; wbin wraps repeatedly.
        for (int k = 0; k < 40; k++) begin
            check("stream_read", 64'(entry(wabs - 5)), 64'(payload(wabs - 5)));
            rabs      = wabs - 4;
            ridx      = gray4(rabs);
            enq_valid = 1'b1;
            enq_bits  = payload(wabs);
            check("stream_no_stall", 64'(enq_ready), 64'd1);
            step();
            wabs++;
            check("stream_widx", 64'(widx), 64'(gray4(wabs)));
            check("stream_entry", 64'(entry(wabs - 1)), 64'(payload(wabs - 1)));
        end
        enq_valid = 1'b0;
        step();
        step();
        step();
        p1 = rabs;
        p2 = rabs;
        p3 = rabs;

        // Randomised Gray-stepping sink with a scoreboard of beat order.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1 && rabs < wabs) begin
                check("rand_read", 64'(entry(rabs)), 64'(payload(rabs)));
                rabs++;
            end
            ridx      = gray4(rabs);
            enq_valid = ($urandom_range(0, 2) != 0);
            enq_bits  = payload(wabs);
            exp_rdy   = (wabs - p3) < 8;
            check("rand_ready", 64'(enq_ready), 64'(exp_rdy));
            step();
            if (enq_valid && exp_rdy) wabs++;
            p3 = p2;
            p2 = p1;
            p1 = rabs;
            check("rand_widx", 64'(widx), 64'(gray4(wabs)));
        end

        // Reset while the producer holds beats: no write on the reset edges.
        slot      = wabs % 8;
        reset_n   = 1'b0;
        ridx      = '0;
        enq_valid = 1'b1;
        enq_bits  = 44'hBEEF;
        step();
        check("midreset_widx", 64'(widx), 64'd0);
        check("midreset_sync", 64'(dut.ridx_s), 64'd0);
        check("midreset_no_write", 64'(entry(slot)), 64'(payload(wabs - 8)));
        for (int i = 0; i < 4; i++) begin
            step();
            check("midreset_hold_widx", 64'(widx), 64'd0);
        end
        reset_n   = 1'b1;
        enq_valid = 1'b0;
        check("post_reset_ready", 64'(enq_ready), 64'd1);
        enq_valid = 1'b1;
        enq_bits  = 44'h77;
        step();
        check("post_reset_widx", 64'(widx), 64'd1);
        check("post_reset_entry0", 64'(entry(0)), 64'h77);
        enq_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
